// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM between two readers.
// Optional grant statistics counters are enabled with ROM_ARB_STATS_EN.
module rom_read_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
`ifdef ROM_ARB_STATS_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          grant0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          grant1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [CW-1:0] gcnt0,
    output logic [CW-1:0] gcnt1
`endif
);

    logic          grant0_q, grant0_d;
    logic          grant1_q, grant1_d;
    logic          rvalid0_q, rvalid1_q;
    logic          ptr_q, ptr_d;
    logic [AW-1:0] romAddr_q, romAddr_d;
    logic          elig0, elig1;

    // A requester in its grant cycle is not eligible, so a req that is
    // still high while being dropped cannot win a second time.
    always_comb begin
        elig0     = req0 & ~grant0_q;
        elig1     = req1 & ~grant1_q;
        grant0_d  = elig0 & (~elig1 | ~ptr_q);
        grant1_d  = elig1 & (~elig0 | ptr_q);
        ptr_d     = ptr_q;
        romAddr_d = romAddr_q;
        if (grant0_d) begin
            romAddr_d = addr0;
            ptr_d     = 1'b1;
        end else if (grant1_d) begin
            romAddr_d = addr1;
            ptr_d     = 1'b0;
        end
    end

    // The grant register doubles as the in-flight pipe stage: the ROM
    // samples rom_addr on the next edge, when rvalid is raised.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            ptr_q     <= 1'b0;
            romAddr_q <= '0;
        end else begin
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            rvalid0_q <= grant0_q;
            rvalid1_q <= grant1_q;
            ptr_q     <= ptr_d;
            romAddr_q <= romAddr_d;
        end
    end

    assign grant0   = grant0_q;
    assign grant1   = grant1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rom_addr = romAddr_q;
    assign rdata    = rom_data;

`ifdef ROM_ARB_STATS_EN
    logic [CW-1:0] gcnt0_q, gcnt0_d;
    logic [CW-1:0] gcnt1_q, gcnt1_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (grant0_d && (gcnt0_q != {CW{1'b1}})) gcnt0_d = gcnt0_q + CW'(1);
        if (grant1_d && (gcnt1_q != {CW{1'b1}})) gcnt1_d = gcnt1_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule
